// File: rtl/sync_search_ctrl.sv
// sync_search_ctrl: sync-word search/lock controller around an external
// fixed-latency correlator; tags each accepted word and evaluates its score.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   load_pat, pat      load reference pattern (honoured in IDLE only)
//   start, abort       begin search / return to IDLE dropping in-flight words
//   din_valid, din     received data word stream
//   thresh             minimum score counted as a match
//   corr_a, corr_b     registered word/pattern to the correlator
//   corr_out           correlator score, LAT edges after corr_a/corr_b
//   busy, locked       state flags
//   hit, hit_idx       match pulse and index of the matching word
//   lost               loss-of-lock pulse
module sync_search_ctrl #(
    parameter int LAT      = 3,
    parameter int CNT_W    = 8,
    parameter int MISS_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_pat,
    input  logic [15:0]      pat,
    input  logic             start,
    input  logic             abort,
    input  logic             din_valid,
    input  logic [15:0]      din,
    input  logic [4:0]       thresh,
    output logic [15:0]      corr_a,
    output logic [15:0]      corr_b,
    input  logic [4:0]       corr_out,
    output logic             busy,
    output logic             locked,
    output logic             hit,
    output logic [CNT_W-1:0] hit_idx,
    output logic             lost
);

    localparam int MW = $clog2(MISS_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_LOCKED
    } state_t;

    state_t           state_q;
    logic [15:0]      pat_q;
    logic [15:0]      corr_a_q;
    logic [15:0]      corr_b_q;
    logic [CNT_W-1:0] idx_q;
    logic [CNT_W-1:0] idx_d;
    logic [CNT_W-1:0] hit_idx_q;
    logic [MW-1:0]    miss_q;
    logic [MW-1:0]    miss_d;
    logic             hit_q;
    logic             lost_q;

    // Tag pipeline: stage LAT lines up with the score of that word on corr_out.
    logic [LAT:0]     tag_vld_q;
    logic [CNT_W-1:0] tag_idx_q [LAT+1];

    logic accept;
    logic eval;
    logic match;

    assign accept = din_valid && (state_q != S_IDLE);
    assign eval   = tag_vld_q[LAT];
    assign match  = (corr_out >= thresh);
    assign idx_d  = idx_q + 1'b1;
    assign miss_d = miss_q + 1'b1;

    always_ff @(posedge clk) begin
        hit_q  <= 1'b0;
        lost_q <= 1'b0;
        if (rst) begin
            state_q   <= S_IDLE;
            pat_q     <= '0;
            corr_a_q  <= '0;
            corr_b_q  <= '0;
            idx_q     <= '0;
            hit_idx_q <= '0;
            miss_q    <= '0;
            tag_vld_q <= '0;
            for (int i = 0; i <= LAT; i++) begin
                tag_idx_q[i] <= '0;
            end
        end else if (abort) begin
            // Clearing the valid tags suppresses every in-flight evaluation.
            state_q   <= S_IDLE;
            tag_vld_q <= '0;
        end else begin
            tag_vld_q[0] <= accept;
            tag_idx_q[0] <= idx_q;
            for (int i = 1; i <= LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_idx_q[i] <= tag_idx_q[i-1];
            end

            if (accept) begin
                corr_a_q <= din;
                corr_b_q <= pat_q;
                idx_q    <= idx_d;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (load_pat) begin
                        pat_q <= pat;
                    end
                    if (start) begin
                        state_q   <= S_SEARCH;
                        idx_q     <= '0;
                        miss_q    <= '0;
                        tag_vld_q <= '0;
                    end
                end
                S_SEARCH: begin
                    if (eval && match) begin
                        hit_q     <= 1'b1;
                        hit_idx_q <= tag_idx_q[LAT];
                        miss_q    <= '0;
                        state_q   <= S_LOCKED;
                    end
                end
                S_LOCKED: begin
                    if (eval) begin
                        if (match) begin
                            hit_q     <= 1'b1;
                            hit_idx_q <= tag_idx_q[LAT];
                            miss_q    <= '0;
                        end else if (miss_d == MW'(MISS_MAX)) begin
                            lost_q  <= 1'b1;
                            miss_q  <= '0;
                            state_q <= S_SEARCH;
                        end else begin
                            miss_q <= miss_d;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign corr_a  = corr_a_q;
    assign corr_b  = corr_b_q;
    assign busy    = (state_q != S_IDLE);
    assign locked  = (state_q == S_LOCKED);
    assign hit     = hit_q;
    assign hit_idx = hit_idx_q;
    assign lost    = lost_q;

endmodule

// File: tb/tb_sync_search_ctrl.sv
// tb_sync_search_ctrl: scoreboard bench for sync_search_ctrl with a
// behavioural correlator of latency LAT.
module tb_sync_search_ctrl;

    localparam int LAT = 3;
    localparam int CNT_W = 8;
    localparam int MISS_MAX = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             load_pat;
    logic [15:0]      pat;
    logic             start;
    logic             abort;
    logic             din_valid;
    logic [15:0]      din;
    logic [4:0]       thresh;
    logic [15:0]      corr_a;
    logic [15:0]      corr_b;
    logic [4:0]       corr_out;
    logic             busy;
    logic             locked;
    logic             hit;
    logic [CNT_W-1:0] hit_idx;
    logic             lost;

    sync_search_ctrl #(
        .LAT(LAT),
        .CNT_W(CNT_W),
        .MISS_MAX(MISS_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load_pat(load_pat),
        .pat(pat),
        .start(start),
        .abort(abort),
        .din_valid(din_valid),
        .din(din),
        .thresh(thresh),
        .corr_a(corr_a),
        .corr_b(corr_b),
        .corr_out(corr_out),
        .busy(busy),
        .locked(locked),
        .hit(hit),
        .hit_idx(hit_idx),
        .lost(lost)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] score(input logic [15:0] a, input logic [15:0] b);
        logic [4:0] s;
        s = '0;
        for (int i = 0; i < 16; i++) begin
            s = s + 5'(a[i] ~^ b[i]);
        end
        return s;
    endfunction

    // Behavioural correlator: score appears LAT edges after corr_a/corr_b.
    logic [4:0] pipe [LAT];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= score(corr_a, corr_b);
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign corr_out = pipe[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        int         cyc;
        logic       hit;
        logic       lost;
        logic [7:0] idx;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    logic [7:0] bidx;

    // Each accepted word has a due cycle; pulses must appear exactly there.
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            chk("hit", 32'(hit), 32'(e.hit));
            chk("lost", 32'(lost), 32'(e.lost));
            if (e.hit) chk("hit_idx", 32'(hit_idx), 32'(e.idx));
        end else if (hit || lost) begin
            chk("spurious", {30'b0, hit, lost}, 32'b0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] w, input logic h, input logic l);
        din = w;
        din_valid = 1'b1;
        q.push_back('{cyc + LAT + 2, h, l, bidx});
        bidx = bidx + 8'd1;
        step();
        din_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (LAT + 3) step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        load_pat = 1'b0;
        pat = '0;
        start = 1'b0;
        abort = 1'b0;
        din_valid = 1'b0;
        din = '0;
        thresh = 5'd16;
        bidx = '0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_corr_a", 32'(corr_a), 32'h0);
        chk("rst_corr_b", 32'(corr_b), 32'h0);
        chk("rst_hit", 32'(hit), 32'h0);
        chk("rst_hit_idx", 32'(hit_idx), 32'h0);
        chk("rst_lost", 32'(lost), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_locked", 32'(locked), 32'h0);
        step();
        rst = 1'b0;

        // Load pattern, search, ignored load during SEARCH, first lock.
        pat = 16'hA5A5;
        load_pat = 1'b1;
        step();
        load_pat = 1'b0;
        pulse_start();
        @(negedge clk);
        chk("busy_search", 32'(busy), 32'h1);
        chk("locked_search", 32'(locked), 32'h0);
        step();
        pat = 16'hFFFF;
        load_pat = 1'b1;
        step();
        load_pat = 1'b0;
        bidx = 8'd0;
        send(16'h0000, 1'b0, 1'b0);
        send(16'hA5A5, 1'b1, 1'b0);
        drain();
        chk("locked_1", 32'(locked), 32'h1);
        chk("corr_b_hold", 32'(corr_b), 32'hA5A5);

        // start while LOCKED must not reset the index.
        pulse_start();
        thresh = 5'd15;
        send(16'hA5A4, 1'b1, 1'b0);
        drain();
        thresh = 5'd16;
        send(16'hA5A4, 1'b0, 1'b0);
        send(16'hA5A5, 1'b1, 1'b0);
        send(16'h5A5A, 1'b0, 1'b0);
        send(16'h5A5A, 1'b0, 1'b0);
        send(16'h5A5A, 1'b0, 1'b0);
        send(16'h5A5A, 1'b0, 1'b1);
        drain();
        chk("locked_lost", 32'(locked), 32'h0);
        chk("busy_lost", 32'(busy), 32'h1);

        // Abort (with start) while two matches are in flight.
        send(16'hA5A5, 1'b0, 1'b0);
        send(16'hA5A5, 1'b0, 1'b0);
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("busy_abort", 32'(busy), 32'h0);
        drain();

        // Index wrap after 256 words.
        pulse_start();
        bidx = 8'd0;
        for (int i = 0; i < 256; i++) send(16'h0000, 1'b0, 1'b0);
        send(16'hA5A5, 1'b1, 1'b0);
        drain();
        chk("locked_wrap", 32'(locked), 32'h1);

        // Threshold extremes.
        thresh = 5'd0;
        send(16'h5A5A, 1'b1, 1'b0);
        drain();
        thresh = 5'd17;
        send(16'hA5A5, 1'b0, 1'b0);
        drain();

        // Reset with a word in flight.
        thresh = 5'd16;
        send(16'hA5A5, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("rst2_busy", 32'(busy), 32'h0);
        chk("rst2_hit_idx", 32'(hit_idx), 32'h0);
        chk("rst2_corr_a", 32'(corr_a), 32'h0);
        step();
        rst = 1'b0;
        drain();
        chk("q_empty", 32'(q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_search_ctrl.md
SYNC_SEARCH_CTRL -- requirements
Module: sync_search_ctrl

Interface
REQ-001 SHALL have parameter LAT, default 3: fixed latency, in clock edges, of the external correlator from corr_a/corr_b to corr_out.
REQ-002 SHALL have parameter CNT_W, default 8: width of the word index counter and hit_idx.
REQ-003 SHALL have parameter MISS_MAX, default 4: number of consecutive below-threshold scores in LOCKED that declare loss of lock.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 load_pat  input  1  load pat into the pattern register.
REQ-007 pat  input  16  reference sync pattern.
REQ-008 start  input  1  begin search.
REQ-009 abort  input  1  return to IDLE and discard in-flight scores.
REQ-010 din_valid  input  1  din carries a word this cycle.
REQ-011 din  input  16  received data word.
REQ-012 thresh  input  5  minimum score (0..16) counted as a match.
REQ-013 corr_a  output  16  registered data word to the correlator.
REQ-014 corr_b  output  16  registered pattern to the correlator.
REQ-015 corr_out  input  5  correlator score: count of equal bit positions, 0..16.
REQ-016 busy  output  1  state is not IDLE.
REQ-017 locked  output  1  state is LOCKED.
REQ-018 hit  output  1  one-cycle pulse per evaluated score >= thresh.
REQ-019 hit_idx  output  CNT_W  index of the word that produced the most recent hit.
REQ-020 lost  output  1  one-cycle pulse on loss of lock.

Function
REQ-021 SHALL implement states IDLE, SEARCH and LOCKED.
REQ-022 load_pat SHALL update the pattern register only in IDLE and SHALL be ignored in other states.
REQ-023 IDLE + start, with abort low -> SEARCH; index counter, miss counter and pipeline tags cleared on the same edge.
REQ-024 start outside IDLE SHALL be ignored; abort SHALL win over start.
REQ-025 abort in any state -> IDLE on the next edge; all pipeline tags cleared, so no hit or lost pulse follows from words already in flight.
REQ-026 A word SHALL be accepted only when din_valid=1 and the state is SEARCH or LOCKED.
  - On acceptance: corr_a<=din, corr_b<=pattern, a tag carrying the current index is pushed, and the index counter increments.
  - Otherwise corr_a and corr_b hold their values.
REQ-027 Index counter SHALL wrap from 2^CNT_W-1 to 0.
REQ-028 Tag pipeline SHALL be LAT+1 stages; a tag reaching the final stage marks corr_out as that word's score.
  - Evaluation occurs at accept edge + LAT + 1.
  - hit/lost are registered, so they are high in the cycle after the evaluating edge (LAT+2 cycles after acceptance).
REQ-029 Evaluation in SEARCH with score >= thresh (unsigned 5-bit compare): hit pulse, hit_idx<=tag index, miss counter cleared, state -> LOCKED.
REQ-030 Evaluation in SEARCH with score < thresh: no action.
REQ-031 Evaluation in LOCKED with score >= thresh: hit pulse, hit_idx updated, miss counter cleared.
REQ-032 Evaluation in LOCKED with score < thresh: miss counter increments.
  - When it reaches MISS_MAX: lost pulse, state -> SEARCH, miss counter cleared.
REQ-033 In-flight words SHALL be evaluated under the state current at evaluation time, including after LOCKED<->SEARCH transitions.
REQ-034 thresh=0 SHALL make every evaluated word a hit; thresh>16 SHALL never hit.
REQ-035 hit_idx SHALL hold its value between hits.

Reset
REQ-036 rst=1 SHALL force IDLE and clear the pattern register, counters and tags.
  - Outputs: corr_a=0, corr_b=0, hit=0, hit_idx=0, lost=0, busy=0, locked=0.
REQ-037 rst SHALL override start, abort and load_pat on the same edge; reset mid-search discards all in-flight scores.

Verification
REQ-038 Reset, load pat=16'hA5A5, start, thresh=16, din 16'h0000 then 16'hA5A5 -> single hit with hit_idx=1 at LAT+2 cycles after the second word; locked=1.
REQ-039 thresh=15, din=16'hA5A4 (score 15) -> hit; thresh=16, same din -> no hit.
REQ-040 LOCKED, then 4 words 16'h5A5A (score 0) -> lost pulse after the 4th evaluation only; locked=0, busy=1.
REQ-041 Two matching words in flight, abort asserted -> no hit pulse afterwards; busy=0 on the next cycle.
REQ-042 CNT_W=8: 256 non-matching words, then a match -> hit_idx=0 (wrap).
REQ-043 load_pat with pat=16'hFFFF during SEARCH -> corr_b stays 16'hA5A5.
